// File: rtl/bin_gray_stream_enc.sv
// Streaming binary-to-Gray encoder with a registered main stage and a skid slot.
// Ports: clk, rst, in_valid/in_ready/b_in in; out_valid/out_ready/g_out/adj_out out.
module bin_gray_stream_enc #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] g_out,
  output logic         adj_out
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] g_q, g_d;
  logic [N-1:0] skid_g_q, skid_g_d;
  logic [N-1:0] prev_q, prev_d;
  logic         out_valid_q, out_valid_d;
  logic         adj_q, adj_d;
  logic         skid_valid_q, skid_valid_d;
  logic         skid_adj_q, skid_adj_d;
  logic         first_q, first_d;
  logic         in_ready_q, in_ready_d;

  logic         in_fire;
  logic         out_fire;
  logic [N-1:0] g_new;
  logic [N-1:0] diff;
  logic         adj_new;

  always_comb begin
    g_new   = b_in ^ (b_in >> 1);
    diff    = g_new ^ prev_q;
    // exactly one bit set: non-zero and a power of two
    adj_new = !first_q && (diff != '0) && ((diff & (diff - ONE)) == '0);
    in_fire  = in_valid && in_ready_q;
    out_fire = out_valid_q && out_ready;

    g_d          = g_q;
    adj_d        = adj_q;
    out_valid_d  = out_valid_q;
    skid_g_d     = skid_g_q;
    skid_adj_d   = skid_adj_q;
    skid_valid_d = skid_valid_q;
    prev_d       = prev_q;
    first_d      = first_q;

    if (in_fire) begin
      prev_d  = g_new;
      first_d = 1'b0;
    end

    if (!out_valid_q || out_fire) begin
      // main slot frees up: skid word has priority over the input
      if (skid_valid_q) begin
        g_d          = skid_g_q;
        adj_d        = skid_adj_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        g_d         = g_new;
        adj_d       = adj_new;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_g_d     = g_new;
      skid_adj_d   = adj_new;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q          <= '0;
      adj_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_g_q     <= '0;
      skid_adj_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      prev_q       <= '0;
      first_q      <= 1'b1;
      in_ready_q   <= 1'b1;
    end else begin
      g_q          <= g_d;
      adj_q        <= adj_d;
      out_valid_q  <= out_valid_d;
      skid_g_q     <= skid_g_d;
      skid_adj_q   <= skid_adj_d;
      skid_valid_q <= skid_valid_d;
      prev_q       <= prev_d;
      first_q      <= first_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign g_out     = g_q;
  assign adj_out   = adj_q;

endmodule

// File: tb/tb_bin_gray_stream_enc.sv
// Self-checking bench for bin_gray_stream_enc: queue-based reference model,
// per-cycle compare on the falling edge, and literal checks of directed scenarios.
module tb_bin_gray_stream_enc;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] g_out;
  logic         adj_out;

  int tests = 0;
  int fails = 0;

  bin_gray_stream_enc #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .g_out    (g_out),
    .adj_out  (adj_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         adj;
  } word_t;

  // reference model: words held by the block, in order
  word_t        mq[$];
  logic [N-1:0] m_prev = '0;
  logic         m_first = 1'b1;
  int           accepts = 0;

  word_t        outlog[$];
  int           ready_low = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ones(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_prev  = '0;
      m_first = 1'b1;
    end else begin
      logic acc;
      logic emit;
      word_t w;
      acc  = in_valid && (mq.size() < 2);
      emit = (mq.size() > 0) && out_ready;
      if (acc) begin
        w.g     = b_in ^ (b_in >> 1);
        w.adj   = !m_first && (ones(w.g ^ m_prev) == 1);
        m_prev  = w.g;
        m_first = 1'b0;
        accepts++;
      end
      if (emit) void'(mq.pop_front());
      if (acc) mq.push_back(w);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), int'(mq.size() > 0));
      chk("in_ready", int'(in_ready), int'(mq.size() < 2));
      if (mq.size() > 0 && out_valid) begin
        chk("g_out", int'(g_out), int'(mq[0].g));
        chk("adj_out", int'(adj_out), int'(mq[0].adj));
      end
      if (out_valid && out_ready) outlog.push_back({g_out, adj_out});
      if (!in_ready) ready_low++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] b);
    int t = 0;
    in_valid = 1'b1;
    b_in     = b;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) chk("push_timeout", 1, 0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_log(input string name, input int gs[], input int as[]);
    chk({name, "_len"}, outlog.size(), gs.size());
    for (int i = 0; i < gs.size() && i < outlog.size(); i++) begin
      chk({name, "_g"}, int'(outlog[i].g), gs[i]);
      chk({name, "_adj"}, int'(outlog[i].adj), as[i]);
    end
    outlog.delete();
  endtask

  initial begin
    int sg[];
    int sa[];
    int cyc;
    int target;

    rst = 1'b1;
    step();
    step();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_g_out", int'(g_out), 0);
    chk("reset_adj_out", int'(adj_out), 0);
    rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);

    // sweep 0..15 then 0
    out_ready = 1'b1;
    ready_low = 0;
    for (int b = 0; b < 16; b++) push(N'(b));
    push('0);
    step();
    step();
    sg = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    sa = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    check_log("sweep", sg, sa);
    chk("sweep_ready_low", ready_low, 0);

    // backpressure
    out_ready = 1'b0;
    push(4'd3);
    push(4'd4);
    in_valid = 1'b1;
    b_in     = 4'd5;
    step();
    step();
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_g_hold", int'(g_out), 2);
    out_ready = 1'b1;
    push(4'd5);
    step();
    step();
    step();
    sg = '{2, 6, 7};
    sa = '{1, 1, 1};
    check_log("bp", sg, sa);

    // non-adjacent and repeated values
    push(4'd0);
    push(4'd5);
    push(4'd5);
    push(4'd6);
    step();
    step();
    sg = '{0, 7, 7, 5};
    sa = '{0, 0, 0, 1};
    check_log("rep", sg, sa);

    // simultaneous in/out, skid never used
    ready_low = 0;
    for (int b = 9; b < 15; b++) push(N'(b));
    step();
    step();
    chk("simul_ready_low", ready_low, 0);
    chk("simul_count", outlog.size(), 6);
    outlog.delete();

    // reset mid-operation
    out_ready = 1'b0;
    push(4'd1);
    push(4'd2);
    in_valid = 1'b1;
    b_in     = 4'd7;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rstmid_out_valid", int'(out_valid), 0);
    chk("rstmid_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    step();
    step();
    chk("rstmid_still_empty", int'(out_valid), 0);
    outlog.delete();
    push(4'd3);
    step();
    step();
    sg = '{2};
    sa = '{0};
    check_log("rstmid", sg, sa);

    // randomised handshake
    target = accepts + 1000;
    cyc = 0;
    while (accepts < target && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      b_in      = N'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
    end
    if (cyc >= 20000) chk("rand_timeout", 1, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("rand_drained", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_gray_stream_enc.md
Name: bin_gray_stream_enc

Overview:
- Streaming 4-bit (parameterised) binary-to-Gray encoder with a valid/ready handshake on both sides.
- Inverse-direction companion to the team's Gray-to-binary converter: produces the Gray words that converter consumes, e.g. pointer codes for clock-domain crossing.
- One registered pipeline stage plus a skid register, so `in_ready` is fully registered.
- Each output word carries an adjacency flag: the word differs from the previous output in exactly one bit.

Parameters:
- N, 4, data width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  source presents a word on b_in.
- in_ready  output  1  block can accept a word this cycle.
- b_in  input  N  binary word.
- out_valid  output  1  g_out and adj_out are valid.
- out_ready  input  1  sink accepts the output word this cycle.
- g_out  output  N  Gray word, equal to b ^ (b >> 1).
- adj_out  output  1  g_out differs from the previously transferred g_out in exactly one bit.

Behaviour:
- Encoding:
  - g[N-1] = b[N-1].
  - g[i] = b[i+1] ^ b[i] for i = N-2..0.
  - Purely bitwise; no arithmetic, no width growth.
- Transfers:
  - Input transfer occurs on a clk edge where in_valid && in_ready.
  - Output transfer occurs on a clk edge where out_valid && out_ready.
- Storage:
  - Main register holds the word presented on g_out/adj_out.
  - Skid register holds one extra word.
  - All outputs are driven directly from flops.
- in_ready = NOT skid_valid (registered).
- Latency:
  - A word accepted at edge k appears on g_out with out_valid=1 after edge k, i.e. 1 cycle.
  - Full throughput (1 word/cycle) while out_ready stays high.
- Backpressure:
  - If out_valid=1, out_ready=0 and an input transfer occurs, the word goes to the skid register and in_ready drops to 0 after that edge.
  - When the main word transfers out, the skid word moves to main at the same edge and in_ready returns to 1.
  - Simultaneous output transfer and input transfer with the skid empty: the new word loads main directly.
- Stability:
  - While out_valid=1 and out_ready=0, g_out and adj_out hold stable.
  - out_valid never deasserts without a transfer.
- Ordering: words leave in acceptance order; none dropped or duplicated.
- adj_out:
  - Computed at input acceptance as popcount(g_new ^ g_prev) == 1.
  - g_prev is the Gray code of the previously accepted word; it updates on every input transfer.
  - The first word accepted after reset has adj_out=0 (a first-flag is cleared on the first acceptance).
  - Identical consecutive words give adj_out=0.
- Wrap-around: binary all-ones to zero (e.g. 15 -> 0 gives Gray 8 -> 0) is a normal single-bit change, so adj_out=1.
- Reset values (sync, wins over all other activity at the same edge):
  - out_valid=0, g_out=0, adj_out=0.
  - Skid empty, so in_ready=1 from the first edge after rst falls.
  - g_prev=0, first-flag set.
- Reset mid-operation:
  - Main and skid contents are discarded.
  - No transfer is counted on the reset edge, even if in_valid/in_ready or out_valid/out_ready are high.
- Inputs are ignored (no acceptance) while rst=1.

Test Plan:
- Sweep, N=4, out_ready=1: after reset, stream b_in=0..15 back-to-back, then 0 -> g_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 one cycle after each accept. adj_out=0 on the first word, 1 on all others including the 8->0 wrap. in_ready stays 1 throughout.
- Backpressure, out_ready=0 for 4 cycles, in_valid=1 with b_in=3 then 4:
  - g_out=2 holds stable and out_valid=1.
  - in_ready drops to 0 after the second accept; b_in=5 offered meanwhile is not accepted.
  - On release, g_out=2 then 6 (adj=1) then 7 (adj=1) appear on consecutive cycles, with no loss or duplication.
- Non-adjacent and repeated values: accept b_in=0, 5, 5, 6:
  - g_out=0 (adj 0), 7 (adj 0), 7 (adj 0), 5 (adj 1).
- Simultaneous in/out transfer with skid empty and out_ready=1, in_valid=1 every cycle, b_in incrementing from 9 -> one output per cycle, skid never used, in_ready constant 1.
- Reset mid-operation:
  - Fill main and skid (out_ready=0, accept b=1,2), then assert rst for 1 cycle with in_valid=1 and b_in=7.
  - Next cycle: out_valid=0, in_ready=1, nothing from before reset emerges, b=7 is not captured.
  - Next accepted b=3 gives g_out=2 with adj_out=0.
- Randomised handshake (1000 words, random in_valid/out_ready): a scoreboard compares g_out against b^(b>>1) and adj_out against a reference popcount model; check that no handshake rule is violated.
